eth_tx_arb: RTL
===============

ETH_TX_ARB -- requirements
Module: eth_tx_arb

Interface
REQ-001 The block SHALL have parameter ifg_len, default 16'd4, giving the number of idle cycles inserted after each frame (TX_ARB_IFG_EN builds only).
REQ-002 The block SHALL have parameter cnt_width, default 32, giving the width of each per-source frame counter.
REQ-003 The block SHALL have port clk156, input, 1 bit: the 156.25 MHz clock for all logic.
REQ-004 The block SHALL have port sys_rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 The block SHALL have ports s0_axis_tvalid, s0_axis_tdata, s0_axis_tkeep, s0_axis_tlast: inputs, 1/64/8/1 bits, AXI-Stream frames from generator 0.
REQ-006 The block SHALL have port s0_axis_tready, output, 1 bit: ready to generator 0.
REQ-007 The block SHALL have ports s1_axis_tvalid, s1_axis_tdata, s1_axis_tkeep, s1_axis_tlast, s1_axis_tready, with the same widths and directions as source 0, for generator 1.
REQ-008 The block SHALL have ports m_axis_tx_tvalid, m_axis_tx_tdata, m_axis_tx_tkeep, m_axis_tx_tlast, m_axis_tx_tuser: outputs, 1/64/8/1/1 bits, to the 10G MAC TX.
REQ-009 The block SHALL have port m_axis_tx_tready, input, 1 bit: MAC ready.
REQ-010 The block SHALL have ports frame_cnt0 and frame_cnt1, outputs, cnt_width bits: count of completed frames per source.
REQ-011 The block SHALL have port grant, output, 2 bits: one-hot current owner, 2'b00 when none.

Function
REQ-012 The block SHALL implement states ARB_IDLE, ARB_GRANT0, ARB_GRANT1 and ARB_GAP.
REQ-013 In ARB_IDLE, with only sN_axis_tvalid=1, the block SHALL enter ARB_GRANTN on the next clock.
REQ-014 In ARB_IDLE, with both tvalid=1, the block SHALL grant the source not in register last_grant (round-robin), then update last_grant to the granted source.
REQ-015 In ARB_GRANTN, m_axis_tx_tvalid/tdata/tkeep/tlast SHALL equal the sN inputs combinationally, sN_axis_tready SHALL equal m_axis_tx_tready, and the other source's tready SHALL be 0.
REQ-016 Outside a grant state, m_axis_tx_tvalid, tlast, tdata and tkeep SHALL be 0 and both source treadys SHALL be 0.
REQ-017 m_axis_tx_tuser SHALL be tied to 0.
REQ-018 A grant SHALL be held for the whole frame; it is released only on the beat where tvalid, tready and tlast are all 1.
REQ-019 The owner's tvalid dropping mid-frame SHALL NOT release the grant.
REQ-020 On frame release, frame_cntN SHALL increment by 1 on that same clock edge and wrap from all-ones to 0.
REQ-021 On frame release, the next state SHALL be ARB_GAP when TX_ARB_IFG_EN is defined and ifg_len>0, otherwise ARB_IDLE.
REQ-022 ARB_GAP SHALL load a 16-bit counter with ifg_len-1, decrement it each clock, and go to ARB_IDLE when the counter is 0; m_axis_tx_tready is ignored in this state.
REQ-023 The minimum bus-idle time between frames SHALL be 1 cycle (ARB_IDLE) plus ifg_len cycles when the gap is enabled.
REQ-024 An unreachable state encoding SHALL recover to ARB_IDLE on the next clock.

Reset
REQ-025 While sys_rst_n=0, asynchronously: state=ARB_IDLE, last_grant=1 (so source 0 wins first), gap counter=0, frame_cnt0=frame_cnt1=0, grant=2'b00, and all tvalid/tready outputs=0.
REQ-026 On a reset asserted mid-frame, the partial frame SHALL be dropped without counting, and arbitration SHALL restart from ARB_IDLE after sys_rst_n deasserts.

Configuration
REQ-027 With macro TX_ARB_IFG_EN defined, ARB_GAP and its counter SHALL be built and behave per REQ-022.
REQ-028 Without TX_ARB_IFG_EN, ARB_GAP and its counter SHALL NOT exist, ifg_len SHALL be ignored, and release SHALL go directly to ARB_IDLE.

Verification
REQ-029 Reset release; only s0 valid with a 3-beat frame, tready=1 -> grant=01 one cycle after valid, 3 beats out, last tkeep passed through unchanged, frame_cnt0=1.
REQ-030 Both sources continuously valid, tready=1 -> grants alternate 0,1,0,1; after 4 frames frame_cnt0=2 and frame_cnt1=2.
REQ-031 Grant s1; drop s0 tvalid and tready=0 for 5 cycles mid-frame -> s0_axis_tready=0 throughout, grant stays 10, no beat duplicated or lost.
REQ-032 TX_ARB_IFG_EN defined, ifg_len=4 -> exactly 5 cycles with m_axis_tx_tvalid=0 between frames; with the macro undefined -> exactly 1 cycle.
REQ-033 Assert sys_rst_n=0 on beat 2 of a 6-beat s0 frame -> outputs 0 immediately, frame_cnt0 stays 0, and the next frame after release is granted cleanly.
REQ-034 frame_cnt1 preset (force) to 32'hFFFF_FFFF, then one s1 frame -> frame_cnt1=0.

Source files
------------

// File: rtl/eth_tx_arb.sv
// ============================================================================
// Module   : eth_tx_arb
// Purpose  : Round-robin, frame-granular arbiter that merges two AXI-Stream
//            generators onto one 10G MAC TX stream. Optional inter-frame
//            gap insertion is enabled by the TX_ARB_IFG_EN macro.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module eth_tx_arb #(
    parameter logic [15:0] ifg_len   = 16'd4,
    parameter int          cnt_width = 32
) (
    input  wire logic                 clk156,
    input  wire logic                 sys_rst_n,

    input  wire logic                 s0_axis_tvalid,
    input  wire logic [63:0]          s0_axis_tdata,
    input  wire logic [7:0]           s0_axis_tkeep,
    input  wire logic                 s0_axis_tlast,
    output logic                      s0_axis_tready,

    input  wire logic                 s1_axis_tvalid,
    input  wire logic [63:0]          s1_axis_tdata,
    input  wire logic [7:0]           s1_axis_tkeep,
    input  wire logic                 s1_axis_tlast,
    output logic                      s1_axis_tready,

    output logic                      m_axis_tx_tvalid,
    output logic [63:0]               m_axis_tx_tdata,
    output logic [7:0]                m_axis_tx_tkeep,
    output logic                      m_axis_tx_tlast,
    output logic                      m_axis_tx_tuser,
    input  wire logic                 m_axis_tx_tready,

    output logic [cnt_width-1:0]      frame_cnt0,
    output logic [cnt_width-1:0]      frame_cnt1,
    output logic [1:0]                grant
);

`ifdef TX_ARB_IFG_EN
    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_GRANT0 = 2'd1,
        ARB_GRANT1 = 2'd2,
        ARB_GAP    = 2'd3
    } arb_state_t;
`else
    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_GRANT0 = 2'd1,
        ARB_GRANT1 = 2'd2
    } arb_state_t;
`endif

    arb_state_t             r_state;
    arb_state_t             w_next_state;
    arb_state_t             w_after_release;
    logic                   r_last_grant;
    logic [cnt_width-1:0]   r_frame_cnt0;
    logic [cnt_width-1:0]   r_frame_cnt1;
    logic                   w_release0;
    logic                   w_release1;

    // A frame is released only on its final accepted beat.
    assign w_release0 = (r_state == ARB_GRANT0) && s0_axis_tvalid && m_axis_tx_tready && s0_axis_tlast;
    assign w_release1 = (r_state == ARB_GRANT1) && s1_axis_tvalid && m_axis_tx_tready && s1_axis_tlast;

`ifdef TX_ARB_IFG_EN
    logic [15:0] r_gap_cnt;

    assign w_after_release = (ifg_len != 16'd0) ? ARB_GAP : ARB_IDLE;

    always_ff @(posedge clk156 or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_gap_cnt <= 16'd0;
        end else if (w_next_state == ARB_GAP && r_state != ARB_GAP) begin
            r_gap_cnt <= ifg_len - 16'd1;
        end else if (r_state == ARB_GAP && r_gap_cnt != 16'd0) begin
            r_gap_cnt <= r_gap_cnt - 16'd1;
        end
    end
`else
    logic w_unused_ifg;

    assign w_unused_ifg    = ^ifg_len;
    assign w_after_release = ARB_IDLE;
`endif

    always_ff @(posedge clk156 or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state <= ARB_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ARB_IDLE: begin
                if (s0_axis_tvalid && s1_axis_tvalid) begin
                    w_next_state = r_last_grant ? ARB_GRANT0 : ARB_GRANT1;
                end else if (s0_axis_tvalid) begin
                    w_next_state = ARB_GRANT0;
                end else if (s1_axis_tvalid) begin
                    w_next_state = ARB_GRANT1;
                end
            end
            ARB_GRANT0: begin
                if (w_release0) begin
                    w_next_state = w_after_release;
                end
            end
            ARB_GRANT1: begin
                if (w_release1) begin
                    w_next_state = w_after_release;
                end
            end
`ifdef TX_ARB_IFG_EN
            ARB_GAP: begin
                if (r_gap_cnt == 16'd0) begin
                    w_next_state = ARB_IDLE;
                end
            end
`endif
            default: w_next_state = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk156 or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_last_grant <= 1'b1;
        end else if (r_state == ARB_IDLE) begin
            if (w_next_state == ARB_GRANT0) begin
                r_last_grant <= 1'b0;
            end else if (w_next_state == ARB_GRANT1) begin
                r_last_grant <= 1'b1;
            end
        end
    end

    // Counters wrap naturally from all-ones to zero.
    always_ff @(posedge clk156 or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_frame_cnt0 <= '0;
            r_frame_cnt1 <= '0;
        end else begin
            if (w_release0) begin
                r_frame_cnt0 <= r_frame_cnt0 + {{(cnt_width-1){1'b0}}, 1'b1};
            end
            if (w_release1) begin
                r_frame_cnt1 <= r_frame_cnt1 + {{(cnt_width-1){1'b0}}, 1'b1};
            end
        end
    end

    always_comb begin
        m_axis_tx_tvalid = 1'b0;
        m_axis_tx_tdata  = 64'd0;
        m_axis_tx_tkeep  = 8'd0;
        m_axis_tx_tlast  = 1'b0;
        s0_axis_tready   = 1'b0;
        s1_axis_tready   = 1'b0;
        grant            = 2'b00;
        case (r_state)
            ARB_GRANT0: begin
                m_axis_tx_tvalid = s0_axis_tvalid;
                m_axis_tx_tdata  = s0_axis_tdata;
                m_axis_tx_tkeep  = s0_axis_tkeep;
                m_axis_tx_tlast  = s0_axis_tlast;
                s0_axis_tready   = m_axis_tx_tready;
                grant            = 2'b01;
            end
            ARB_GRANT1: begin
                m_axis_tx_tvalid = s1_axis_tvalid;
                m_axis_tx_tdata  = s1_axis_tdata;
                m_axis_tx_tkeep  = s1_axis_tkeep;
                m_axis_tx_tlast  = s1_axis_tlast;
                s1_axis_tready   = m_axis_tx_tready;
                grant            = 2'b10;
            end
            default: begin
            end
        endcase
    end

    assign m_axis_tx_tuser = 1'b0;
    assign frame_cnt0      = r_frame_cnt0;
    assign frame_cnt1      = r_frame_cnt1;

endmodule

`default_nettype wire
